// File: rtl/cl_ddr_stat_mux.sv
// Bridges a single-outstanding config/stat request bus onto three sh_ddr stat ports,
// with a per-request ack timeout, local status/count/mask registers and a masked irq.
module cl_ddr_stat_mux #(
    parameter int          TIMEOUT      = 256,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic [9:0]       cfg_addr,
    input  logic             cfg_wr,
    input  logic             cfg_rd,
    input  logic [31:0]      cfg_wdata,
    output logic             cfg_ack,
    output logic [31:0]      cfg_rdata,
    output logic [2:0][7:0]  sh_ddr_stat_addr,
    output logic [2:0]       sh_ddr_stat_wr,
    output logic [2:0]       sh_ddr_stat_rd,
    output logic [2:0][31:0] sh_ddr_stat_wdata,
    input  logic [2:0]       ddr_sh_stat_ack,
    input  logic [2:0][31:0] ddr_sh_stat_rdata,
    input  logic [2:0][7:0]  ddr_sh_stat_int,
    output logic             stat_irq
);
    localparam int               CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       SEL_LOCAL = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT, ST_RESP} state_t;

    state_t           state_reg;
    logic [1:0]       sel_reg;
    logic             is_wr_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [2:0]       timeout_sticky_reg, timeout_sticky_next;
    logic             overrun_sticky_reg, overrun_sticky_next;
    logic [2:0]       int_pending_reg, int_pending_next;
    logic [2:0]       int_mask_reg;
    logic [15:0]      timeout_cnt_reg;

    logic             req, accept, local_wr;
    logic [1:0]       req_sel;
    logic [7:0]       req_reg;
    logic [2:0]       ch_hit, wr_next, rd_next, int_any, timeout_set;
    logic             sel_ack, timed_out;
    logic [2:0]       clr_ts, clr_ip;
    logic             clr_ov;
    logic [31:0]      status_word, local_rdata;

    assign req      = cfg_wr | cfg_rd;
    assign req_sel  = cfg_addr[9:8];
    assign req_reg  = cfg_addr[7:0];
    assign accept   = (state_reg == ST_IDLE) && req;
    assign local_wr = accept && (req_sel == SEL_LOCAL) && cfg_wr;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            assign ch_hit[gi]  = accept && (req_sel == 2'(gi));
            assign wr_next[gi] = ch_hit[gi] && cfg_wr;
            assign rd_next[gi] = ch_hit[gi] && !cfg_wr;
            assign int_any[gi] = |ddr_sh_stat_int[gi];
        end
    endgenerate

    // An ack on the last counted cycle beats the timeout.
    assign sel_ack     = (state_reg == ST_WAIT) && ddr_sh_stat_ack[sel_reg];
    assign timed_out   = (state_reg == ST_WAIT) && !sel_ack && (wait_cnt_reg == CNT_LAST);
    assign timeout_set = timed_out ? 3'(3'b001 << sel_reg) : 3'b000;

    assign status_word = {21'd0, int_pending_reg, 4'd0, overrun_sticky_reg, timeout_sticky_reg};
    assign clr_ts      = (local_wr && req_reg == 8'h00) ? cfg_wdata[2:0]  : 3'b000;
    assign clr_ov      = local_wr && (req_reg == 8'h00) && cfg_wdata[3];
    assign clr_ip      = (local_wr && req_reg == 8'h00) ? cfg_wdata[10:8] : 3'b000;

    // Write-1-to-clear with set taking priority over a same-cycle clear.
    assign timeout_sticky_next = (timeout_sticky_reg & ~clr_ts) | timeout_set;
    assign overrun_sticky_next = (overrun_sticky_reg & ~clr_ov) | ((state_reg != ST_IDLE) && req);
    assign int_pending_next    = (int_pending_reg & ~clr_ip) | int_any;

    always_comb begin
        local_rdata = '0;
        if (!cfg_wr) begin
            case (req_reg)
                8'h00:   local_rdata = status_word;
                8'h04:   local_rdata = {16'd0, timeout_cnt_reg};
                8'h08:   local_rdata = {29'd0, int_mask_reg};
                default: local_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_reg       <= ST_IDLE;
            sel_reg         <= '0;
            is_wr_reg       <= 1'b0;
            wait_cnt_reg    <= '0;
            cfg_ack         <= 1'b0;
            cfg_rdata       <= '0;
            timeout_cnt_reg <= '0;
            int_mask_reg    <= '0;
        end else begin
            cfg_ack   <= 1'b0;
            cfg_rdata <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        sel_reg   <= req_sel;
                        is_wr_reg <= cfg_wr;
                        if (req_sel == SEL_LOCAL) begin
                            cfg_ack   <= 1'b1;
                            cfg_rdata <= local_rdata;
                            state_reg <= ST_RESP;
                            if (cfg_wr && req_reg == 8'h04) timeout_cnt_reg <= '0;
                            if (cfg_wr && req_reg == 8'h08) int_mask_reg <= cfg_wdata[2:0];
                        end else begin
                            state_reg <= ST_STROBE;
                        end
                    end
                end
                ST_STROBE: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    if (sel_ack) begin
                        cfg_ack   <= 1'b1;
                        cfg_rdata <= is_wr_reg ? 32'd0 : ddr_sh_stat_rdata[sel_reg];
                        state_reg <= ST_RESP;
                    end else if (timed_out) begin
                        cfg_ack   <= 1'b1;
                        cfg_rdata <= is_wr_reg ? 32'd0 : TIMEOUT_DATA;
                        state_reg <= ST_RESP;
                        if (timeout_cnt_reg != 16'hFFFF) timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            sh_ddr_stat_wr     <= '0;
            sh_ddr_stat_rd     <= '0;
            sh_ddr_stat_addr   <= '0;
            sh_ddr_stat_wdata  <= '0;
            timeout_sticky_reg <= '0;
            overrun_sticky_reg <= 1'b0;
            int_pending_reg    <= '0;
            stat_irq           <= 1'b0;
        end else begin
            sh_ddr_stat_wr <= wr_next;
            sh_ddr_stat_rd <= rd_next;
            for (int c = 0; c < 3; c++) begin
                if (ch_hit[c]) begin
                    sh_ddr_stat_addr[c]  <= req_reg;
                    sh_ddr_stat_wdata[c] <= cfg_wdata;
                end
            end
            timeout_sticky_reg <= timeout_sticky_next;
            overrun_sticky_reg <= overrun_sticky_next;
            int_pending_reg    <= int_pending_next;
            stat_irq           <= |(int_pending_reg & int_mask_reg);
        end
    end
endmodule

// File: tb/tb_cl_ddr_stat_mux.sv
// Randomised bench for cl_ddr_stat_mux: a delayed-ack responder per channel and a
// register-level model of the local status/count/mask space predict every response.
`timescale 1ns/1ps
module tb_cl_ddr_stat_mux;
    localparam int          TO      = 256;
    localparam logic [31:0] TO_DATA = 32'hDEAD_DEAD;

    logic             clk = 1'b0;
    logic             sync_rst = 1'b1;
    logic [9:0]       cfg_addr = '0;
    logic             cfg_wr = 1'b0, cfg_rd = 1'b0;
    logic [31:0]      cfg_wdata = '0;
    logic             cfg_ack;
    logic [31:0]      cfg_rdata;
    logic [2:0][7:0]  sh_ddr_stat_addr;
    logic [2:0]       sh_ddr_stat_wr, sh_ddr_stat_rd;
    logic [2:0][31:0] sh_ddr_stat_wdata;
    logic [2:0]       resp_ack = '0, extra_ack = '0, ack_w;
    logic [2:0][31:0] resp_data = '0;
    logic [2:0][7:0]  int_lines = '0;
    logic             stat_irq;

    int resp_delay [3];
    int cd [3];
    int wr_cnt [3];
    int rd_cnt [3];
    int ack_cnt = 0;
    int n_checks = 0, n_fail = 0;

    logic [2:0] m_ts = '0, m_ip = '0, m_mask = '0;
    logic       m_ov = 1'b0;
    int         m_tcnt = 0;

    assign ack_w = resp_ack | extra_ack;

    cl_ddr_stat_mux #(.TIMEOUT(TO), .TIMEOUT_DATA(TO_DATA)) dut (
        .clk(clk), .sync_rst(sync_rst), .cfg_addr(cfg_addr), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
        .sh_ddr_stat_addr(sh_ddr_stat_addr), .sh_ddr_stat_wr(sh_ddr_stat_wr),
        .sh_ddr_stat_rd(sh_ddr_stat_rd), .sh_ddr_stat_wdata(sh_ddr_stat_wdata),
        .ddr_sh_stat_ack(ack_w), .ddr_sh_stat_rdata(resp_data),
        .ddr_sh_stat_int(int_lines), .stat_irq(stat_irq)
    );

    always #5 clk = ~clk;

    // Responder acks a channel resp_delay cycles after its strobe (0 = never); also counts pulses.
    initial begin
        for (int c = 0; c < 3; c++) begin cd[c] = 0; wr_cnt[c] = 0; rd_cnt[c] = 0; end
        forever begin
            @(posedge clk);
            for (int c = 0; c < 3; c++) begin
                if (sh_ddr_stat_wr[c]) wr_cnt[c]++;
                if (sh_ddr_stat_rd[c]) rd_cnt[c]++;
                if (sh_ddr_stat_wr[c] || sh_ddr_stat_rd[c]) cd[c] = resp_delay[c];
                else if (cd[c] > 0) cd[c]--;
            end
            if (cfg_ack) ack_cnt++;
            #1;
            for (int c = 0; c < 3; c++) resp_ack[c] = (cd[c] == 1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [9:0] addr, input logic [31:0] wd);
        cfg_wr = wr; cfg_rd = rd; cfg_addr = addr; cfg_wdata = wd;
        step(1);
        cfg_wr = 1'b0; cfg_rd = 1'b0;
    endtask

    // Waits (bounded) for cfg_ack; cyc counts cycles from the call, then steps past the ack.
    task automatic wait_ack(input int max_cyc, output int cyc, output logic [31:0] rd, output bit got);
        got = 1'b0; cyc = 0; rd = '0;
        while (!got && cyc <= max_cyc) begin
            if (cfg_ack) begin got = 1'b1; rd = cfg_rdata; end
            else begin step(1); cyc++; end
        end
        if (got) step(1);
    endtask

    // Expected response of a local register access, and its effect on the model.
    task automatic model_local(input logic wr, input logic [7:0] a, input logic [31:0] wd, output logic [31:0] exp);
        exp = '0;
        if (!wr) begin
            if (a == 8'h00) exp = {21'd0, m_ip, 4'd0, m_ov, m_ts};
            else if (a == 8'h04) exp = 32'(m_tcnt);
            else if (a == 8'h08) exp = {29'd0, m_mask};
        end else begin
            if (a == 8'h00) begin m_ts &= ~wd[2:0]; m_ov &= ~wd[3]; m_ip &= ~wd[10:8]; end
            else if (a == 8'h04) m_tcnt = 0;
            else if (a == 8'h08) m_mask = wd[2:0];
        end
    endtask

    task automatic model_timeout(input int ch);
        m_ts[ch] = 1'b1;
        if (m_tcnt < 65535) m_tcnt++;
    endtask

    task automatic test_reset();
        logic [31:0] exp, rd; int cyc; bit got;
        sync_rst = 1'b1;
        step(3);
        n_checks++; if (cfg_ack !== 1'b0 || cfg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_cfg: ack=%0b rdata=%08h want 0/0", cfg_ack, cfg_rdata); end
        n_checks++; if (sh_ddr_stat_wr !== 3'b0 || sh_ddr_stat_rd !== 3'b0) begin n_fail++; $display("FAIL reset_strobe: wr=%03b rd=%03b want 0", sh_ddr_stat_wr, sh_ddr_stat_rd); end
        n_checks++; if (sh_ddr_stat_addr !== 24'd0 || sh_ddr_stat_wdata !== 96'd0) begin n_fail++; $display("FAIL reset_addr_data: addr=%06h wdata=%024h want 0", sh_ddr_stat_addr, sh_ddr_stat_wdata); end
        n_checks++; if (stat_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b want 0", stat_irq); end
        sync_rst = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            model_local(1'b0, 8'(i * 4), 32'd0, exp);
            issue(1'b0, 1'b1, {2'd3, 8'(i * 4)}, 32'd0);
            wait_ack(10, cyc, rd, got);
            n_checks++; if (!got || cyc != 0 || rd !== exp) begin n_fail++; $display("FAIL reset_local_%0d: got=%0b cyc=%0d rdata=%08h want cyc 0 rdata %08h", i, got, cyc, rd, exp); end
        end
    endtask

    task automatic test_read_ch1();
        logic [31:0] rd; int cyc; bit got; int rd0, wr0;
        resp_delay[1] = 3; resp_data[1] = 32'h1234_5678;
        rd0 = rd_cnt[0] + rd_cnt[1] + rd_cnt[2]; wr0 = wr_cnt[0] + wr_cnt[1] + wr_cnt[2];
        issue(1'b0, 1'b1, 10'h110, 32'd0);
        n_checks++; if (sh_ddr_stat_rd !== 3'b010 || sh_ddr_stat_wr !== 3'b000) begin n_fail++; $display("FAIL rd1_strobe: rd=%03b wr=%03b want 010/000", sh_ddr_stat_rd, sh_ddr_stat_wr); end
        n_checks++; if (sh_ddr_stat_addr[1] !== 8'h10) begin n_fail++; $display("FAIL rd1_addr: got %02h want 10", sh_ddr_stat_addr[1]); end
        wait_ack(20, cyc, rd, got);
        n_checks++; if (!got || cyc != 4) begin n_fail++; $display("FAIL rd1_latency: got=%0b cyc=%0d want 4", got, cyc); end
        n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd1_rdata: got %08h want 12345678", rd); end
        n_checks++; if ((rd_cnt[0] + rd_cnt[1] + rd_cnt[2]) - rd0 != 1 || (wr_cnt[0] + wr_cnt[1] + wr_cnt[2]) != wr0) begin n_fail++; $display("FAIL rd1_pulses: rd pulses %0d wr pulses %0d want 1/0", (rd_cnt[0] + rd_cnt[1] + rd_cnt[2]) - rd0, (wr_cnt[0] + wr_cnt[1] + wr_cnt[2]) - wr0); end
        n_checks++; if (cfg_ack !== 1'b0 || cfg_rdata !== 32'd0) begin n_fail++; $display("FAIL rd1_after: ack=%0b rdata=%08h want 0/0", cfg_ack, cfg_rdata); end
        resp_delay[1] = 0;
    endtask

    task automatic test_timeout_write();
        logic [31:0] rd, exp; int cyc; bit got;
        resp_delay[2] = 0;
        issue(1'b1, 1'b0, 10'h23C, 32'hA5A5_0001);
        n_checks++; if (sh_ddr_stat_wr !== 3'b100 || sh_ddr_stat_wdata[2] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL to_strobe: wr=%03b wdata=%08h want 100/a5a50001", sh_ddr_stat_wr, sh_ddr_stat_wdata[2]); end
        wait_ack(TO + 10, cyc, rd, got);
        n_checks++; if (!got || cyc != TO + 1 || rd !== 32'd0) begin n_fail++; $display("FAIL to_resp: got=%0b cyc=%0d rdata=%08h want cyc %0d rdata 0", got, cyc, rd, TO + 1); end
        model_timeout(2);
        for (int i = 0; i < 4; i++) begin
            logic wr; logic [7:0] a; logic [31:0] wd;
            wr = (i == 2); a = (i == 1) ? 8'h04 : 8'h00; wd = (i == 2) ? 32'd4 : 32'd0;
            model_local(wr, a, wd, exp);
            issue(wr, !wr, {2'd3, a}, wd);
            wait_ack(10, cyc, rd, got);
            n_checks++; if (!got || rd !== exp) begin n_fail++; $display("FAIL to_local_%0d: got=%0b rdata=%08h want %08h", i, got, rd, exp); end
        end
    endtask

    task automatic test_ack_priority();
        logic [31:0] rd, exp; int cyc; bit got;
        extra_ack = 3'b101; resp_delay[1] = TO; resp_data[1] = $urandom;
        issue(1'b0, 1'b1, {2'd1, 8'($urandom)}, 32'd0);
        wait_ack(TO + 10, cyc, rd, got);
        n_checks++; if (!got || cyc != TO + 1 || rd !== resp_data[1]) begin n_fail++; $display("FAIL prio_resp: got=%0b cyc=%0d rdata=%08h want cyc %0d rdata %08h", got, cyc, rd, TO + 1, resp_data[1]); end
        extra_ack = 3'b000; resp_delay[1] = 0;
        for (int i = 0; i < 2; i++) begin
            model_local(1'b0, 8'(i * 4), 32'd0, exp);
            issue(1'b0, 1'b1, {2'd3, 8'(i * 4)}, 32'd0);
            wait_ack(10, cyc, rd, got);
            n_checks++; if (!got || rd !== exp) begin n_fail++; $display("FAIL prio_local_%0d: rdata=%08h want %08h", i, rd, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp; int cyc, a0, w0, r0; bit got;
        resp_delay[0] = 5;
        a0 = ack_cnt; w0 = wr_cnt[0]; r0 = rd_cnt[0] + rd_cnt[1] + rd_cnt[2];
        issue(1'b1, 1'b1, 10'h044, $urandom);
        n_checks++; if (sh_ddr_stat_wr !== 3'b001 || sh_ddr_stat_rd !== 3'b000) begin n_fail++; $display("FAIL b2b_strobe: wr=%03b rd=%03b want 001/000", sh_ddr_stat_wr, sh_ddr_stat_rd); end
        step(1);
        cfg_rd = 1'b1; cfg_addr = 10'h300;
        step(1);
        cfg_rd = 1'b0;
        wait_ack(20, cyc, rd, got);
        n_checks++; if (!got || cyc != 4 || rd !== 32'd0) begin n_fail++; $display("FAIL b2b_resp: got=%0b cyc=%0d rdata=%08h want cyc 4 rdata 0", got, cyc, rd); end
        m_ov = 1'b1;
        step(3);
        n_checks++; if (ack_cnt - a0 != 1 || wr_cnt[0] - w0 != 1 || (rd_cnt[0] + rd_cnt[1] + rd_cnt[2]) != r0) begin n_fail++; $display("FAIL b2b_counts: acks %0d wr %0d rd %0d want 1/1/0", ack_cnt - a0, wr_cnt[0] - w0, (rd_cnt[0] + rd_cnt[1] + rd_cnt[2]) - r0); end
        model_local(1'b0, 8'h00, 32'd0, exp);
        issue(1'b0, 1'b1, 10'h300, 32'd0);
        wait_ack(10, cyc, rd, got);
        n_checks++; if (!got || rd !== exp || rd[3] !== 1'b1) begin n_fail++; $display("FAIL b2b_status: rdata=%08h want %08h", rd, exp); end
        resp_delay[0] = 0;
    endtask

    task automatic test_interrupts();
        logic [31:0] rd, exp; int cyc; bit got;
        int_lines[1] = 8'h01; step(1); int_lines[1] = 8'h00;
        m_ip[1] = 1'b1;
        step(1);
        n_checks++; if (stat_irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %0b want 0", stat_irq); end
        model_local(1'b0, 8'h00, 32'd0, exp);
        issue(1'b0, 1'b1, 10'h300, 32'd0);
        wait_ack(10, cyc, rd, got);
        n_checks++; if (rd !== exp || rd[9] !== 1'b1) begin n_fail++; $display("FAIL irq_status: rdata=%08h want %08h", rd, exp); end
        model_local(1'b1, 8'h08, 32'd2, exp);
        issue(1'b1, 1'b0, 10'h308, 32'd2);
        wait_ack(10, cyc, rd, got);
        n_checks++; if (stat_irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmasked: got %0b want 1", stat_irq); end
        // A clear coinciding with a new interrupt leaves the bit set.
        int_lines[1] = 8'h80;
        model_local(1'b1, 8'h00, 32'h200, exp);
        m_ip[1] = 1'b1;
        issue(1'b1, 1'b0, 10'h300, 32'h200);
        int_lines[1] = 8'h00;
        step(1);
        model_local(1'b0, 8'h00, 32'd0, exp);
        issue(1'b0, 1'b1, 10'h300, 32'd0);
        wait_ack(10, cyc, rd, got);
        n_checks++; if (rd !== exp || rd[9] !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: rdata=%08h want %08h", rd, exp); end
        model_local(1'b1, 8'h00, 32'h200, exp);
        issue(1'b1, 1'b0, 10'h300, 32'h200);
        n_checks++; if (stat_irq !== 1'b1) begin n_fail++; $display("FAIL irq_clear_lag: got %0b want 1", stat_irq); end
        step(1);
        n_checks++; if (stat_irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %0b want 0", stat_irq); end
        step(1);
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, wd; logic [7:0] a; logic wr, rdf; int ch, d, cyc, exp_cyc; bit got;
        for (int t = 0; t < 24; t++) begin
            ch = $urandom_range(0, 3); wr = 1'($urandom_range(0, 1));
            rdf = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            a = 8'($urandom); wd = $urandom; d = 0;
            if (ch == 3) begin
                if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 2) * 4);
                model_local(wr, a, wd, exp);
                exp_cyc = 0;
                issue(wr, rdf, {2'd3, a}, wd);
            end else begin
                d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
                resp_delay[ch] = d; resp_data[ch] = $urandom;
                exp_cyc = (d == 0) ? TO + 1 : d + 1;
                exp = wr ? 32'd0 : ((d == 0) ? TO_DATA : resp_data[ch]);
                if (d == 0) model_timeout(ch);
                issue(wr, rdf, {2'(ch), a}, wd);
                n_checks++; if (sh_ddr_stat_wr !== (wr ? 3'(1 << ch) : 3'b0) || sh_ddr_stat_rd !== (wr ? 3'b0 : 3'(1 << ch)) || sh_ddr_stat_addr[ch] !== a) begin
                    n_fail++; $display("FAIL rnd_strobe_%0d: wr=%03b rd=%03b addr=%02h want ch %0d wr %0b addr %02h", t, sh_ddr_stat_wr, sh_ddr_stat_rd, sh_ddr_stat_addr[ch], ch, wr, a);
                end
            end
            wait_ack(TO + 10, cyc, rd, got);
            $display("txn %0d ch=%0d wr=%0b addr=%02h delay=%0d cyc=%0d rdata=%08h", t, ch, wr, a, d, cyc, rd);
            n_checks++; if (!got || cyc != exp_cyc || rd !== exp) begin n_fail++; $display("FAIL rnd_resp_%0d: got=%0b cyc=%0d rdata=%08h want cyc %0d rdata %08h", t, got, cyc, rd, exp_cyc, exp); end
            n_checks++; if (stat_irq !== |(m_ip & m_mask)) begin n_fail++; $display("FAIL rnd_irq_%0d: got %0b want %0b", t, stat_irq, |(m_ip & m_mask)); end
            if (ch < 3) resp_delay[ch] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            model_local(1'b0, 8'(i * 4), 32'd0, exp);
            issue(1'b0, 1'b1, {2'd3, 8'(i * 4)}, 32'd0);
            wait_ack(10, cyc, rd, got);
            n_checks++; if (!got || rd !== exp) begin n_fail++; $display("FAIL rnd_final_%0d: rdata=%08h want %08h", i, rd, exp); end
        end
    endtask

    task automatic test_reset_during_wait();
        logic [31:0] rd, exp; int cyc, a0; bit got;
        resp_delay[0] = 10; resp_data[0] = $urandom;
        issue(1'b0, 1'b1, 10'h020, 32'd0);
        step(3);
        sync_rst = 1'b1;
        step(1);
        n_checks++; if (cfg_ack !== 1'b0 || cfg_rdata !== 32'd0 || stat_irq !== 1'b0) begin n_fail++; $display("FAIL rstw_cfg: ack=%0b rdata=%08h irq=%0b want 0", cfg_ack, cfg_rdata, stat_irq); end
        n_checks++; if (sh_ddr_stat_wr !== 3'b0 || sh_ddr_stat_rd !== 3'b0 || sh_ddr_stat_addr !== 24'd0 || sh_ddr_stat_wdata !== 96'd0) begin n_fail++; $display("FAIL rstw_ch: wr=%03b rd=%03b addr=%06h want 0", sh_ddr_stat_wr, sh_ddr_stat_rd, sh_ddr_stat_addr); end
        step(1);
        sync_rst = 1'b0;
        m_ts = '0; m_ip = '0; m_mask = '0; m_ov = 1'b0; m_tcnt = 0;
        a0 = ack_cnt;
        step(15);
        n_checks++; if (ack_cnt != a0) begin n_fail++; $display("FAIL rstw_late_ack: cfg_ack pulses %0d want 0", ack_cnt - a0); end
        resp_delay[0] = 0;
        for (int i = 0; i < 3; i++) begin
            model_local(1'b0, 8'((1 - i + 3) % 3 * 4), 32'd0, exp);
            issue(1'b0, 1'b1, {2'd3, 8'((1 - i + 3) % 3 * 4)}, 32'd0);
            wait_ack(10, cyc, rd, got);
            n_checks++; if (!got || rd !== exp) begin n_fail++; $display("FAIL rstw_local_%0d: got=%0b rdata=%08h want %08h", i, got, rd, exp); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_ch1();
        test_timeout_write();
        test_ack_priority();
        test_back_to_back();
        test_interrupts();
        test_random();
        test_reset_during_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
